// File: rtl/shifter_pkg.sv
// Shared types for the pipelined shift/rotate unit: op encoding, per-stage
// control payload and the shift-amount width helper.
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROR = 2'b11
    } sh_op_e;

    // Control half of the stage payload; data, sh and tag travel beside it
    // as separate vectors because their widths follow the module parameters.
    typedef struct packed {
        sh_op_e op;
        logic   fill;
        logic   carry;
    } stage_ctl_t;

    function automatic int shw_of(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the shift unit: shifts or rotates by 2^K when sh[K]
// is set, updates the carry, and registers the full payload.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int K     = 0,
    parameter int WIDTH = 32,
    parameter int SHW   = shw_of(WIDTH),
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             src_vld,
    input  logic [WIDTH-1:0] src_data,
    input  logic [SHW-1:0]   src_sh,
    input  stage_ctl_t       src_ctl,
    input  logic [TAG_W-1:0] src_tag,
    output logic             vld_p0,
    output logic [WIDTH-1:0] data_p0,
    output logic [SHW-1:0]   sh_p0,
    output stage_ctl_t       ctl_p0,
    output logic [TAG_W-1:0] tag_p0
);

    localparam int S = 1 << K;

    logic [WIDTH-1:0] shifted;
    logic             shifted_carry;

    always_comb begin
        shifted       = src_data;
        shifted_carry = src_ctl.carry;
        if (src_sh[K]) begin
            case (src_ctl.op)
                SH_SLL: begin
                    shifted       = src_data << S;
                    shifted_carry = src_data[WIDTH-S];
                end
                SH_SRL: begin
                    shifted       = src_data >> S;
                    shifted_carry = src_data[S-1];
                end
                SH_SRA: begin
                    shifted       = {{S{src_ctl.fill}}, src_data[WIDTH-1:S]};
                    shifted_carry = src_data[S-1];
                end
                // ROR carry is taken from the result MSB at the output
                default: shifted = {src_data[S-1:0], src_data[WIDTH-1:S]};
            endcase
        end
    end

    // stage K register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            sh_p0   <= '0;
            ctl_p0  <= '{op: SH_SLL, fill: 1'b0, carry: 1'b0};
            tag_p0  <= '0;
        end else if (en) begin
            vld_p0  <= src_vld;
            data_p0 <= shifted;
            sh_p0   <= src_sh;
            ctl_p0  <= '{op: src_ctl.op, fill: src_ctl.fill, carry: shifted_carry};
            tag_p0  <= src_tag;
        end
    end

endmodule

// File: rtl/pipelined_shift_unit.sv
// Fully pipelined SLL/SRL/SRA/ROR unit with carry/zero flags, sideband tag
// and valid/ready flow control driven by a single global stall.
module pipelined_shift_unit
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = shw_of(WIDTH),
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [SHW-1:0]   in_sh,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic [TAG_W-1:0] out_tag
);

    logic             stall;
    logic             en;

    logic             src_vld  [SHW];
    logic [WIDTH-1:0] src_data [SHW];
    logic [SHW-1:0]   src_sh   [SHW];
    stage_ctl_t       src_ctl  [SHW];
    logic [TAG_W-1:0] src_tag  [SHW];

    logic             vld_q    [SHW];
    logic [WIDTH-1:0] data_q   [SHW];
    logic [SHW-1:0]   sh_q     [SHW];
    stage_ctl_t       ctl_q    [SHW];
    logic [TAG_W-1:0] tag_q    [SHW];

    // Whole pipe freezes together; empty stages are not compacted
    assign stall    = out_valid & ~out_ready;
    assign en       = ~stall;
    assign in_ready = ~stall;

    // SRA fill is the operand MSB captured at entry; carry starts at 0
    assign src_vld[0]  = in_valid;
    assign src_data[0] = in_data;
    assign src_sh[0]   = in_sh;
    assign src_ctl[0]  = '{op: sh_op_e'(in_op), fill: in_data[WIDTH-1], carry: 1'b0};
    assign src_tag[0]  = in_tag;

    for (genvar k = 1; k < SHW; k++) begin : g_link
        assign src_vld[k]  = vld_q[k-1];
        assign src_data[k] = data_q[k-1];
        assign src_sh[k]   = sh_q[k-1];
        assign src_ctl[k]  = ctl_q[k-1];
        assign src_tag[k]  = tag_q[k-1];
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .K     (k),
            .WIDTH (WIDTH),
            .SHW   (SHW),
            .TAG_W (TAG_W)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .src_vld  (src_vld[k]),
            .src_data (src_data[k]),
            .src_sh   (src_sh[k]),
            .src_ctl  (src_ctl[k]),
            .src_tag  (src_tag[k]),
            .vld_p0   (vld_q[k]),
            .data_p0  (data_q[k]),
            .sh_p0    (sh_q[k]),
            .ctl_p0   (ctl_q[k]),
            .tag_p0   (tag_q[k])
        );
    end

    // output flags from the last stage register
    assign out_valid = vld_q[SHW-1];
    assign out_data  = data_q[SHW-1];
    assign out_tag   = tag_q[SHW-1];
    assign out_carry = (ctl_q[SHW-1].op == SH_ROR) ? data_q[SHW-1][WIDTH-1]
                                                   : ctl_q[SHW-1].carry;
    assign out_zero  = (data_q[SHW-1] == '0);

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Self-checking bench for pipelined_shift_unit: directed vector table,
// random streaming against a reference model, stall and mid-stream reset.
module tb_pipelined_shift_unit;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [SHW-1:0]   in_sh;
    logic [WIDTH-1:0] in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    pipelined_shift_unit #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_sh     (in_sh),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [4:0]  sh;
        logic [31:0] data;
        logic [3:0]  tag;
        logic [31:0] exp_data;
        logic        exp_carry;
        logic        exp_zero;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        carry;
        logic        zero;
        logic [3:0]  tag;
    } res_t;

    res_t exp_q[$];
    vec_t tab[9];
    int   n_vec = 0;
    int   n_err = 0;
    int   pops = 0;
    int   mcyc = 0;
    int   first_pop = 0;
    int   last_pop = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: whole-amount shift arithmetic, carry = last bit shifted out
    function automatic res_t model(input logic [1:0] op, input logic [4:0] sh,
                                   input logic [31:0] d, input logic [3:0] tag);
        res_t        r;
        logic [63:0] dd;
        int          n;
        n       = int'(sh);
        r.tag   = tag;
        r.carry = 1'b0;
        case (op)
            2'd0: begin
                r.data = d << n;
                if (n > 0) r.carry = d[32-n];
            end
            2'd1: begin
                r.data = d >> n;
                if (n > 0) r.carry = d[n-1];
            end
            2'd2: begin
                r.data = $signed(d) >>> n;
                if (n > 0) r.carry = d[n-1];
            end
            default: begin
                dd      = {d, d} >> n;
                r.data  = dd[31:0];
                r.carry = r.data[31];
            end
        endcase
        r.zero = (r.data == 32'd0);
        return r;
    endfunction

    // Scoreboard: record accepted beats, compare every consumed result
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            mcyc++;
            if (rst) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("stale_beat", 32'(out_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_data", out_data, e.data);
                        check("sb_carry", 32'(out_carry), 32'(e.carry));
                        check("sb_zero", 32'(out_zero), 32'(e.zero));
                        check("sb_tag", 32'(out_tag), 32'(e.tag));
                    end
                    pops++;
                    if (pops == 1) first_pop = mcyc;
                    last_pop = mcyc;
                end
                if (in_valid && in_ready)
                    exp_q.push_back(model(in_op, in_sh, in_data, in_tag));
            end
        end
    end

    // Called at posedge+1 with an empty pipe; returns at posedge+1
    task automatic apply_vec(input vec_t v, input string name);
        int lat;
        in_valid = 1'b1;
        in_op    = v.op;
        in_sh    = v.sh;
        in_data  = v.data;
        in_tag   = v.tag;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(SHW));
        check({name, "_data"}, out_data, v.exp_data);
        check({name, "_carry"}, 32'(out_carry), 32'(v.exp_carry));
        check({name, "_zero"}, 32'(out_zero), 32'(v.exp_zero));
        check({name, "_tag"}, 32'(out_tag), 32'(v.tag));
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beat();
        in_op   = 2'($urandom_range(0, 3));
        in_sh   = 5'($urandom_range(0, 31));
        in_data = $urandom;
        in_tag  = 4'($urandom_range(0, 15));
    endtask

    task automatic stream(input int n, input int stall_at, input int stall_len);
        int          sent = 0;
        int          c = 0;
        logic        have = 1'b0;
        logic        snap_ok = 1'b0;
        logic [31:0] s_data = '0;
        logic        s_carry = 1'b0;
        logic        s_zero = 1'b0;
        logic        s_valid = 1'b0;
        logic [3:0]  s_tag = '0;
        pops = 0;
        while ((sent < n || exp_q.size() != 0) && c < 300) begin
            out_ready = !(c >= stall_at && c < stall_at + stall_len);
            if (sent < n) begin
                if (!have) begin
                    rand_beat();
                    have = 1'b1;
                end
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (!out_ready && out_valid) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                if (!snap_ok) begin
                    s_data  = out_data;
                    s_carry = out_carry;
                    s_zero  = out_zero;
                    s_valid = out_valid;
                    s_tag   = out_tag;
                    snap_ok = 1'b1;
                end else begin
                    check("stall_data", out_data, s_data);
                    check("stall_carry", 32'(out_carry), 32'(s_carry));
                    check("stall_zero", 32'(out_zero), 32'(s_zero));
                    check("stall_valid", 32'(out_valid), 32'(s_valid));
                    check("stall_tag", 32'(out_tag), 32'(s_tag));
                end
            end
            if (in_valid && in_ready) begin
                sent++;
                have = 1'b0;
            end
            @(posedge clk);
            #1;
            c++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", 32'(sent), 32'(n));
        check("stream_beats_out", 32'(pops), 32'(n));
        if (stall_len == 0)
            check("stream_throughput_span", 32'(last_pop - first_pop), 32'(n - 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           op     sh     data           tag    exp_data       c     z
        tab[0] = '{2'd0, 5'd31, 32'h0000_0001, 4'd3, 32'h8000_0000, 1'b0, 1'b0};
        tab[1] = '{2'd2, 5'd4,  32'h8000_00F0, 4'd5, 32'hF800_000F, 1'b0, 1'b0};
        tab[2] = '{2'd1, 5'd4,  32'h0000_0018, 4'd6, 32'h0000_0001, 1'b1, 1'b0};
        tab[3] = '{2'd3, 5'd1,  32'h0000_0001, 4'd7, 32'h8000_0000, 1'b1, 1'b0};
        tab[4] = '{2'd0, 5'd0,  32'hFFFF_FFFF, 4'd8, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tab[5] = '{2'd1, 5'd1,  32'h0000_0001, 4'd9, 32'h0000_0000, 1'b1, 1'b1};
        tab[6] = '{2'd2, 5'd31, 32'h8000_0000, 4'hA, 32'hFFFF_FFFF, 1'b0, 1'b0};
        tab[7] = '{2'd3, 5'd31, 32'h8000_0001, 4'hB, 32'h0000_0003, 1'b0, 1'b0};
        tab[8] = '{2'd0, 5'd3,  32'hE000_0001, 4'hC, 32'h0000_0008, 1'b1, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_sh     = '0;
        in_data   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_carry", 32'(out_carry), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd1);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            apply_vec(tab[i], $sformatf("vec%0d", i));

        stream(20, 1000, 0);
        stream(16, 8, 7);

        // three beats in flight, the oldest already at the output
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            rand_beat();
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_data", out_data, 32'd0);
        check("midrst_out_zero", 32'(out_zero), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        pops = 0;
        repeat (10) @(negedge clk);
        check("midrst_no_stale", 32'(pops), 32'd0);
        @(posedge clk);
        #1;
        apply_vec(tab[3], "postrst");
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
